color_input_capture: RTL and testbench

//  Parametrised front end for the player colour buttons of the Genius game.

---
 rtl/color_input_capture.sv | 155 +++++++++++++++
 tb/tb_color_input_capture.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/color_input_capture.sv
// Colour button front end: synchronise, debounce and edge-detect each button,
// encode presses to colour codes and queue them for a valid/ready consumer.
module color_input_capture #(
    parameter int NUM_COLORS      = 4,
    parameter int COLOR_CODEFY_W  = 2,
    parameter int DEBOUNCE_CYCLES = 3,
    parameter int FIFO_DEPTH      = 4
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          enable,
    input  logic                          clear,
    input  logic [NUM_COLORS-1:0]         buttons,
    output logic                          evt_valid,
    input  logic                          evt_ready,
    output logic [COLOR_CODEFY_W-1:0]     evt_color,
    output logic                          evt_multi,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
    output logic                          overflow
);

    localparam int AW    = $clog2(FIFO_DEPTH);
    localparam int EW    = COLOR_CODEFY_W + 1;
    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX    = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [AW:0]      COUNT_FULL = (AW+1)'(FIFO_DEPTH);

    logic [NUM_COLORS-1:0]             sync1_q, sync1_d;
    logic [NUM_COLORS-1:0]             sync2_q, sync2_d;
    logic [NUM_COLORS-1:0]             deb_q, deb_d;
    logic [NUM_COLORS-1:0]             deb_prev_q, deb_prev_d;
    logic [NUM_COLORS-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [FIFO_DEPTH-1:0][EW-1:0]     mem_q, mem_d;
    logic [AW-1:0]                     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]                     rd_ptr_q, rd_ptr_d;
    logic [AW:0]                       count_q, count_d;
    logic                              overflow_q, overflow_d;

    logic [NUM_COLORS-1:0]     press;
    logic [COLOR_CODEFY_W-1:0] enc_color;
    logic                      enc_found;
    logic                      enc_multi;
    logic                      push, pop, full, do_push;

    // The counter tracks how long the synced level has disagreed with the
    // accepted level; any agreement restarts it, which swallows glitches.
    always_comb begin
        sync1_d    = buttons;
        sync2_d    = sync1_q;
        deb_d      = deb_q;
        cnt_d      = cnt_q;
        deb_prev_d = deb_q;
        for (int i = 0; i < NUM_COLORS; i++) begin
            if (sync2_q[i] != deb_q[i]) begin
                if (cnt_q[i] == CNT_MAX) begin
                    deb_d[i] = ~deb_q[i];
                    cnt_d[i] = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + CNT_W'(1);
                end
            end else begin
                cnt_d[i] = '0;
            end
        end
    end

    assign press = deb_q & ~deb_prev_q;

    // Simultaneous presses collapse into one event tagged with the lowest index.
    always_comb begin
        enc_color = '0;
        enc_found = 1'b0;
        enc_multi = 1'b0;
        for (int i = 0; i < NUM_COLORS; i++) begin
            if (press[i]) begin
                if (!enc_found) begin
                    enc_color = COLOR_CODEFY_W'(i);
                    enc_found = 1'b1;
                end else begin
                    enc_multi = 1'b1;
                end
            end
        end
    end

    assign full    = (count_q == COUNT_FULL);
    assign push    = enc_found & enable & ~clear;
    assign pop     = (count_q != '0) & evt_ready & ~clear;
    assign do_push = push & (~full | pop);

    always_comb begin
        mem_d      = mem_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (clear) begin
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
            overflow_d = 1'b0;
        end else begin
            if (do_push) begin
                mem_d[wr_ptr_q] = {enc_multi, enc_color};
                wr_ptr_d        = wr_ptr_q + AW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + AW'(1);
            end
            if (do_push && !pop) begin
                count_d = count_q + (AW+1)'(1);
            end else if (!do_push && pop) begin
                count_d = count_q - (AW+1)'(1);
            end
            if (push && full && !pop) begin
                overflow_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q    <= '0;
            sync2_q    <= '0;
            deb_q      <= '0;
            deb_prev_q <= '0;
            cnt_q      <= '0;
            mem_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            sync2_q    <= sync2_d;
            deb_q      <= deb_d;
            deb_prev_q <= deb_prev_d;
            cnt_q      <= cnt_d;
            mem_q      <= mem_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Handshake: the head is transferred on any rising edge where evt_valid and
    // evt_ready are both high; the head fields hold steady until that happens.
    assign evt_valid  = (count_q != '0);
    assign evt_multi  = mem_q[rd_ptr_q][EW-1];
    assign evt_color  = mem_q[rd_ptr_q][COLOR_CODEFY_W-1:0];
    assign fifo_count = count_q;
    assign overflow   = overflow_q;

endmodule

// File: tb/tb_color_input_capture.sv
// Directed bench for color_input_capture: a scoreboard queue holds expected
// {multi,color} events and a negedge monitor checks each handshake transfer.
module tb_color_input_capture;

    logic       clk = 1'b0;
    logic       rst;
    logic       enable;
    logic       clear;
    logic [3:0] buttons;
    logic       evt_valid;
    logic       evt_ready;
    logic [1:0] evt_color;
    logic       evt_multi;
    logic [2:0] fifo_count;
    logic       overflow;

    int n_checks = 0;
    int n_errors = 0;
    logic [2:0] exp_q[$];

    color_input_capture dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .clear      (clear),
        .buttons    (buttons),
        .evt_valid  (evt_valid),
        .evt_ready  (evt_ready),
        .evt_color  (evt_color),
        .evt_multi  (evt_multi),
        .fifo_count (fifo_count),
        .overflow   (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press_one(input int idx);
        buttons[idx] = 1'b1;
        tick(5);
        buttons[idx] = 1'b0;
        tick(6);
    endtask

    task automatic wait_valid(input string name, input int budget);
        int i = 0;
        while (!evt_valid && i < budget) begin
            tick(1);
            i++;
        end
        check(name, int'(evt_valid), 1);
    endtask

    always @(negedge clk) begin
        if (!rst && evt_valid && evt_ready) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL sb_unexpected: got event %0d expected none", {evt_multi, evt_color});
            end else begin
                check("sb_event", int'({evt_multi, evt_color}), int'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst       = 1'b1;
        enable    = 1'b1;
        clear     = 1'b0;
        buttons   = '0;
        evt_ready = 1'b0;
        tick(3);
        check("rst_valid", int'(evt_valid), 0);
        check("rst_count", int'(fifo_count), 0);
        check("rst_ovf", int'(overflow), 0);
        check("rst_color", int'(evt_color), 0);
        check("rst_multi", int'(evt_multi), 0);
        rst = 1'b0;
        tick(2);

        // T1: single press, exact latency, then one-cycle pop
        buttons[1] = 1'b1;
        tick(5);
        check("t1_early", int'(evt_valid), 0);
        buttons[1] = 1'b0;
        tick(1);
        check("t1_valid", int'(evt_valid), 1);
        check("t1_color", int'(evt_color), 1);
        check("t1_multi", int'(evt_multi), 0);
        check("t1_count", int'(fifo_count), 1);
        exp_q.push_back(3'b001);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("t1_pop_valid", int'(evt_valid), 0);
        check("t1_pop_count", int'(fifo_count), 0);
        tick(8);

        // T2: two-cycle glitch must be ignored
        buttons[0] = 1'b1;
        tick(2);
        buttons[0] = 1'b0;
        tick(12);
        check("t2_count", int'(fifo_count), 0);
        check("t2_valid", int'(evt_valid), 0);

        // T3: blue and yellow together give one multi event, colour 2
        buttons = 4'b1100;
        tick(6);
        buttons = 4'b0000;
        check("t3_count", int'(fifo_count), 1);
        check("t3_color", int'(evt_color), 2);
        check("t3_multi", int'(evt_multi), 1);
        exp_q.push_back(3'b110);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        tick(10);
        check("t3_release_count", int'(fifo_count), 0);

        // T4: five presses into a depth-4 queue
        press_one(0); exp_q.push_back(3'b000);
        press_one(1); exp_q.push_back(3'b001);
        press_one(2); exp_q.push_back(3'b010);
        press_one(3); exp_q.push_back(3'b011);
        press_one(0);
        check("t4_count_full", int'(fifo_count), 4);
        check("t4_ovf", int'(overflow), 1);
        evt_ready = 1'b1;
        tick(4);
        evt_ready = 1'b0;
        check("t4_drained", int'(fifo_count), 0);
        check("t4_ovf_sticky", int'(overflow), 1);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        check("t4_clear_ovf", int'(overflow), 0);
        check("t4_clear_count", int'(fifo_count), 0);

        // T5: full queue, push and pop on the same edge
        press_one(0); exp_q.push_back(3'b000);
        press_one(1); exp_q.push_back(3'b001);
        press_one(2); exp_q.push_back(3'b010);
        press_one(3); exp_q.push_back(3'b011);
        check("t5_full", int'(fifo_count), 4);
        buttons[1] = 1'b1;
        tick(5);
        buttons[1] = 1'b0;
        exp_q.push_back(3'b001);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        check("t5_count_same", int'(fifo_count), 4);
        check("t5_no_ovf", int'(overflow), 0);
        check("t5_head", int'(evt_color), 1);
        tick(6);
        clear = 1'b1;
        tick(1);
        clear = 1'b0;
        exp_q.delete();
        check("t5_clear_count", int'(fifo_count), 0);
        check("t5_clear_valid", int'(evt_valid), 0);

        // T6a: presses with enable low are discarded
        enable = 1'b0;
        buttons[2] = 1'b1;
        tick(8);
        buttons[2] = 1'b0;
        tick(2);
        enable = 1'b1;
        tick(6);
        check("t6_disabled_count", int'(fifo_count), 0);
        check("t6_disabled_ovf", int'(overflow), 0);
        press_one(2);
        exp_q.push_back(3'b010);
        check("t6_reenabled_count", int'(fifo_count), 1);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;

        // T6b: reset mid-debounce with a queued event and a held button
        tick(4);
        press_one(2);
        check("t6_prefill", int'(fifo_count), 1);
        buttons[3] = 1'b1;
        tick(3);
        rst = 1'b1;
        #1;
        check("t6_rst_valid", int'(evt_valid), 0);
        check("t6_rst_count", int'(fifo_count), 0);
        check("t6_rst_color", int'(evt_color), 0);
        check("t6_rst_multi", int'(evt_multi), 0);
        check("t6_rst_ovf", int'(overflow), 0);
        tick(2);
        rst = 1'b0;
        exp_q.push_back(3'b011);
        wait_valid("t6_fresh_press", 20);
        check("t6_fresh_color", int'(evt_color), 3);
        evt_ready = 1'b1;
        tick(1);
        evt_ready = 1'b0;
        buttons = '0;
        tick(8);
        check("t6_final_count", int'(fifo_count), 0);

        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
